// File: rtl/tx_relatorio_serial.sv
// Serial status transmitter: on request, snapshots the elevator status and sends a
// 3-byte 8N1 report frame (status, queue-head object, XOR checksum) on TX.
module tx_relatorio_serial #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       envia,
  input  logic [1:0] andar_atual,
  input  logic [1:0] prox_parada,
  input  logic       sobe,
  input  logic       tem_destino,
  input  logic [1:0] tipo_objeto,
  input  logic [1:0] destino_objeto,
  output logic       TX,
  output logic       ocupado,
  output logic       pronto,
  output logic [3:0] db_estado
);

  localparam int W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [3:0] {
    INICIAL   = 4'd0,
    START     = 4'd1,
    DADOS     = 4'd2,
    STOP      = 4'd3,
    PROX_BYTE = 4'd4,
    FIM       = 4'd5
  } estado_t;

  estado_t        estado, estadoProx;
  logic [W-1:0]   contBit, contBitProx;
  logic [2:0]     idxBit, idxBitProx;
  logic [1:0]     idxByte, idxByteProx;
  logic           captura;
  logic           fimBit;

  logic [1:0]     snapAndar, snapProx, snapTipo, snapDestino;
  logic           snapSobe, snapTem;

  logic [7:0]     byteStatus, byteObjeto, byteAtual;
  logic           txProx, ocupadoProx, prontoProx;

  assign fimBit = (contBit == W'(CLKS_PER_BIT - 1));

  assign byteStatus = {2'b01, snapSobe, snapTem, snapProx, snapAndar};
  assign byteObjeto = {4'b1000, snapTipo, snapDestino};

  always_comb begin
    case (idxByteProx)
      2'd0:    byteAtual = byteStatus;
      2'd1:    byteAtual = byteObjeto;
      default: byteAtual = byteStatus ^ byteObjeto;
    endcase
  end

  // State register, counters, snapshot and registered outputs.
  // NOTE: every sequential assignment is non-blocking so all registers update from
  // the same pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado      <= INICIAL;
      contBit     <= '0;
      idxBit      <= '0;
      idxByte     <= '0;
      snapAndar   <= '0;
      snapProx    <= '0;
      snapSobe    <= 1'b0;
      snapTem     <= 1'b0;
      snapTipo    <= '0;
      snapDestino <= '0;
      TX          <= 1'b1;
      ocupado     <= 1'b0;
      pronto      <= 1'b0;
    end else begin
      estado  <= estadoProx;
      contBit <= contBitProx;
      idxBit  <= idxBitProx;
      idxByte <= idxByteProx;
      if (captura) begin
        snapAndar   <= andar_atual;
        snapProx    <= prox_parada;
        snapSobe    <= sobe;
        snapTem     <= tem_destino;
        snapTipo    <= tipo_objeto;
        snapDestino <= destino_objeto;
      end
      TX      <= txProx;
      ocupado <= ocupadoProx;
      pronto  <= prontoProx;
    end
  end

  // Next-state logic.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    estadoProx  = estado;
    idxBitProx  = idxBit;
    idxByteProx = idxByte;
    captura     = 1'b0;
    contBitProx = fimBit ? '0 : contBit + 1'b1;

    case (estado)
      INICIAL: begin
        if (envia) begin
          estadoProx  = START;
          idxByteProx = 2'd0;
          captura     = 1'b1;
        end
      end
      START: begin
        if (fimBit) begin
          estadoProx = DADOS;
          idxBitProx = 3'd0;
        end
      end
      DADOS: begin
        if (fimBit) begin
          if (idxBit == 3'd7) estadoProx = STOP;
          else                idxBitProx = idxBit + 3'd1;
        end
      end
      STOP: begin
        if (fimBit) begin
          // PROX_BYTE is folded into this exit so the next start bit follows at once.
          if (idxByte < 2'd2) begin
            estadoProx  = START;
            idxByteProx = idxByte + 2'd1;
          end else begin
            estadoProx = FIM;
          end
        end
      end
      PROX_BYTE: begin
        estadoProx  = START;
        idxByteProx = idxByte + 2'd1;
      end
      FIM: begin
        if (envia) begin
          estadoProx  = START;
          idxByteProx = 2'd0;
          captura     = 1'b1;
        end else begin
          estadoProx = INICIAL;
        end
      end
      default: estadoProx = INICIAL;
    endcase

    if (estadoProx != estado || estado == INICIAL) contBitProx = '0;
  end

  // Output logic evaluated on the next state so TX/ocupado/pronto come straight from flops.
  always_comb begin
    txProx      = 1'b1;
    ocupadoProx = 1'b0;
    prontoProx  = 1'b0;
    case (estadoProx)
      START: begin
        txProx      = 1'b0;
        ocupadoProx = 1'b1;
      end
      DADOS: begin
        txProx      = byteAtual[idxBitProx];
        ocupadoProx = 1'b1;
      end
      STOP:    ocupadoProx = 1'b1;
      FIM:     prontoProx  = 1'b1;
      default: ;
    endcase
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_tx_relatorio_serial.sv
// Directed bench for tx_relatorio_serial: decodes the TX line cycle by cycle against
// hand-computed frames, with snapshot, ignored-request, back-to-back and reset cases.
module tb_tx_relatorio_serial;

  localparam int CPB      = 4;
  localparam int BYTE_LEN = 10 * CPB;
  localparam int FRAME    = 30 * CPB;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       envia = 1'b0;
  logic [1:0] andar_atual = '0, prox_parada = '0, tipo_objeto = '0, destino_objeto = '0;
  logic       sobe = 1'b0, tem_destino = 1'b0;
  logic       TX, ocupado, pronto;
  logic [3:0] db_estado;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  tx_relatorio_serial #(.CLKS_PER_BIT(CPB)) dut (
    .clock(clock), .reset(reset), .envia(envia),
    .andar_atual(andar_atual), .prox_parada(prox_parada), .sobe(sobe),
    .tem_destino(tem_destino), .tipo_objeto(tipo_objeto), .destino_objeto(destino_objeto),
    .TX(TX), .ocupado(ocupado), .pronto(pronto), .db_estado(db_estado)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic set_inputs(input logic [1:0] a, input logic [1:0] p, input logic s,
                            input logic t, input logic [1:0] ti, input logic [1:0] d);
    andar_atual = a; prox_parada = p; sobe = s; tem_destino = t;
    tipo_objeto = ti; destino_objeto = d;
  endtask

  function automatic logic exp_bit(input logic [7:0] b0, input logic [7:0] b1,
                                   input logic [7:0] b2, input int c);
    int         bi;
    int         s;
    logic [7:0] by;
    bi = c / BYTE_LEN;
    s  = (c % BYTE_LEN) / CPB;
    by = (bi == 0) ? b0 : (bi == 1) ? b1 : b2;
    if (s == 0) return 1'b0;
    if (s == 9) return 1'b1;
    return by[s-1];
  endfunction

  // Observes one frame starting at the cycle right after the accepting edge, then the
  // FIM cycle, and returns one edge later. mode: 0 plain, 1 inputs cleared mid-frame,
  // 2 extra envia pulse mid-frame.
  task automatic run_frame(input string name, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input int mode);
    logic [7:0] got [3];
    logic [7:0] expv [3];
    int         lineErr = 0;
    int         statErr = 0;
    int         s;
    expv[0] = e0; expv[1] = e1; expv[2] = e2;
    for (int b = 0; b < 3; b++) got[b] = 8'h00;
    for (int c = 0; c < FRAME; c++) begin
      if (TX !== exp_bit(e0, e1, e2, c)) lineErr++;
      if (ocupado !== 1'b1 || pronto !== 1'b0) statErr++;
      s = (c % BYTE_LEN) / CPB;
      if ((c % CPB) == CPB / 2 && s >= 1 && s <= 8) got[c / BYTE_LEN][s-1] = TX;
      if (mode == 1 && c == 50) set_inputs(2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0);
      if (mode == 2 && c == 50) envia = 1'b1;
      if (mode == 2 && c == 51) envia = 1'b0;
      tick;
    end
    for (int b = 0; b < 3; b++) begin
      vectors++;
      if (got[b] !== expv[b]) begin
        miscompares++;
        $display("FAIL %s byte%0d: got 0x%02h, want 0x%02h", name, b, got[b], expv[b]);
      end
    end
    vectors++;
    if (lineErr !== 0) begin
      miscompares++;
      $display("FAIL %s line_timing: %0d bad TX cycles, want 0", name, lineErr);
    end
    vectors++;
    if (statErr !== 0) begin
      miscompares++;
      $display("FAIL %s busy_flags: %0d bad ocupado/pronto cycles, want 0", name, statErr);
    end
    vectors++;
    if ({pronto, ocupado, TX, db_estado} !== {1'b1, 1'b0, 1'b1, 4'd5}) begin
      miscompares++;
      $display("FAIL %s fim_cycle: pronto/ocupado/TX/estado=%b/%b/%b/%0d, want 1/0/1/5",
               name, pronto, ocupado, TX, db_estado);
    end
    tick;
  endtask

  task automatic start_frame;
    envia = 1'b1;
    tick;
    envia = 1'b0;
  endtask

  task automatic check_idle(input string name);
    vectors++;
    if ({pronto, ocupado, TX, db_estado} !== {1'b0, 1'b0, 1'b1, 4'd0}) begin
      miscompares++;
      $display("FAIL %s idle: pronto/ocupado/TX/estado=%b/%b/%b/%0d, want 0/0/1/0",
               name, pronto, ocupado, TX, db_estado);
    end
  endtask

  task automatic test_reset;
    int bad = 0;
    reset = 1'b0;
    repeat (3) tick;
    reset = 1'b1;
    check_idle("reset");
    for (int i = 0; i < 10; i++) begin
      tick;
      if ({pronto, ocupado, TX, db_estado} !== {1'b0, 1'b0, 1'b1, 4'd0}) bad++;
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL reset_quiet: %0d active cycles without envia, want 0", bad);
    end
  endtask

  task automatic test_basic_frame;
    set_inputs(2'd2, 2'd3, 1'b1, 1'b1, 2'd1, 2'd2);
    start_frame;
    run_frame("basic", 8'h7E, 8'h86, 8'hF8, 0);
    check_idle("basic_after");
  endtask

  task automatic test_snapshot;
    set_inputs(2'd2, 2'd3, 1'b1, 1'b1, 2'd1, 2'd2);
    start_frame;
    run_frame("snapshot", 8'h7E, 8'h86, 8'hF8, 1);
    check_idle("snapshot_after");
  endtask

  task automatic test_ignored_request;
    int pulses = 0;
    set_inputs(2'd1, 2'd0, 1'b0, 1'b1, 2'd3, 2'd1);
    // byte0 = 01_0_1_00_01 = 0x51, byte1 = 10_00_11_01 = 0x8D, checksum = 0xDC
    start_frame;
    run_frame("ignored", 8'h51, 8'h8D, 8'hDC, 2);
    for (int i = 0; i < 20; i++) begin
      if (pronto === 1'b1 || ocupado === 1'b1) pulses++;
      tick;
    end
    vectors++;
    if (pulses !== 0) begin
      miscompares++;
      $display("FAIL ignored_extra: %0d busy/pronto cycles after frame, want 0", pulses);
    end
  endtask

  task automatic test_back_to_back;
    set_inputs(2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0);
    envia = 1'b1;
    tick;
    run_frame("b2b_1", 8'h40, 8'h80, 8'hC0, 0);
    vectors++;
    if ({TX, ocupado, db_estado} !== {1'b0, 1'b1, 4'd1}) begin
      miscompares++;
      $display("FAIL b2b_gap: TX/ocupado/estado=%b/%b/%0d, want 0/1/1", TX, ocupado, db_estado);
    end
    run_frame("b2b_2", 8'h40, 8'h80, 8'hC0, 0);
    envia = 1'b0;
    run_frame("b2b_3", 8'h40, 8'h80, 8'hC0, 0);
    check_idle("b2b_after");
  endtask

  task automatic test_mid_frame_reset;
    int bad = 0;
    set_inputs(2'd3, 2'd1, 1'b0, 1'b1, 2'd2, 2'd3);
    start_frame;
    repeat (55) tick;
    reset = 1'b0;
    #1;
    vectors++;
    if ({pronto, ocupado, TX, db_estado} !== {1'b0, 1'b0, 1'b1, 4'd0}) begin
      miscompares++;
      $display("FAIL midreset_now: pronto/ocupado/TX/estado=%b/%b/%b/%0d, want 0/0/1/0",
               pronto, ocupado, TX, db_estado);
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      if (pronto !== 1'b0 || TX !== 1'b1) bad++;
    end
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (pronto !== 1'b0 || ocupado !== 1'b0) bad++;
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL midreset_hold: %0d cycles with pronto/activity, want 0", bad);
    end
    // byte0 = 01_0_1_01_11 = 0x57, byte1 = 10_00_10_11 = 0x8B, checksum = 0xDC
    start_frame;
    run_frame("after_reset", 8'h57, 8'h8B, 8'hDC, 0);
    check_idle("after_reset_idle");
  endtask

  initial begin
    test_reset;
    test_basic_frame;
    test_snapshot;
    test_ignored_request;
    test_back_to_back;
    test_mid_frame_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
